// File: rtl/crc_pkg.sv
// Shared types, preset constants and bit-level helpers for the crc_stream engine.
package crc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } crc_state_e;

  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
  localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;
  localparam logic [31:0] CRC32_RESIDUE    = 32'hC704DD7B;

  // Fold one byte MSB-first into a Galois register of 'width' bits (1..64).
  // Bits above 'width' are kept at zero so callers can truncate freely.
  function automatic logic [63:0] crc_byte_step(input logic [63:0] lfsr,
                                                input logic [7:0]  data_byte,
                                                input logic [63:0] poly,
                                                input int          width);
    logic [63:0] r;
    logic [63:0] mask;
    logic [63:0] top_bit;
    logic        fb;
    mask    = {64{1'b1}} >> (64 - width);
    top_bit = 64'd1 << (width - 1);
    r       = lfsr & mask;
    for (int i = 7; i >= 0; i--) begin
      fb = (|(r & top_bit)) ^ data_byte[i];
      r  = (r << 1) & mask;
      if (fb) r = r ^ (poly & mask);
    end
    return r;
  endfunction

  // Reverse the low 'width' bits of v; result is right-aligned.
  function automatic logic [63:0] bit_reverse(input logic [63:0] v,
                                              input int          width);
    logic [63:0] full;
    full = {<<{v}};
    return full >> (64 - width);
  endfunction

endpackage

// File: rtl/crc_stream_fold.sv
// Combinational multi-byte CRC fold: applies every enabled byte of one beat,
// byte 0 first, to the current register value.
module crc_stream_fold
  import crc_pkg::*;
#(
  parameter int                   DATA_WIDTH = 8,
  parameter int                   CRC_WIDTH  = 16,
  parameter logic [CRC_WIDTH-1:0] POLY       = 16'h1021,
  parameter logic                 REFIN      = 1'b0
) (
  input  logic [CRC_WIDTH-1:0]    lfsr,
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic [CRC_WIDTH-1:0]    next
);

  localparam int BYTES = DATA_WIDTH / 8;

  logic [CRC_WIDTH-1:0] acc;
  logic [7:0]           cur;

  // Chain byte steps; disabled bytes pass the register through untouched.
  always_comb begin
    acc = lfsr;
    cur = '0;
    for (int b = 0; b < BYTES; b++) begin
      cur = data[8*b +: 8];
      if (REFIN) cur = {<<{cur}};
      if (byte_en[b]) acc = CRC_WIDTH'(crc_byte_step(64'(acc), cur, 64'(POLY), CRC_WIDTH));
    end
    next = acc;
  end

endmodule

// File: rtl/crc_stream.sv
// crc_stream: parametrised streaming CRC engine with one registered result
// slot and residue check. Optional statistics counters are built when
// CRC_STREAM_STATS_EN is defined (adds frame_cnt / err_cnt outputs).
//
//   state | meaning
//   IDLE  | no beat of the current frame accepted yet
//   BUSY  | mid-frame, lfsr holds a partial CRC
module crc_stream
  import crc_pkg::*;
#(
  parameter int                   DATA_WIDTH = 8,
  parameter int                   CRC_WIDTH  = 16,
  parameter logic [CRC_WIDTH-1:0] POLY       = 16'h1021,
  parameter logic [CRC_WIDTH-1:0] INIT       = {CRC_WIDTH{1'b1}},
  parameter logic [CRC_WIDTH-1:0] XOR_OUT    = {CRC_WIDTH{1'b0}},
  parameter logic                 REFIN      = 1'b0,
  parameter logic                 REFOUT     = 1'b0,
  parameter logic [CRC_WIDTH-1:0] RESIDUE    = {CRC_WIDTH{1'b0}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic [DATA_WIDTH/8-1:0] s_keep,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic [CRC_WIDTH-1:0]    m_crc,
  output logic                    m_match,
  output logic                    m_valid,
  input  logic                    m_ready
`ifdef CRC_STREAM_STATS_EN
  ,
  output logic [31:0]             frame_cnt,
  output logic [31:0]             err_cnt
`endif
);

  localparam int KEEP_W = DATA_WIDTH / 8;

  crc_state_e           state, state_next;
  logic [CRC_WIDTH-1:0] lfsr;
  logic [CRC_WIDTH-1:0] fold_next;
  logic [CRC_WIDTH-1:0] crc_final;
  logic [KEEP_W-1:0]    byte_en;
  logic [KEEP_W-1:0]    keep_inc;
  logic                 accept;
  logic                 frame_done;
  logic                 frame_ok;

  // One result slot: a new beat may enter whenever the slot is empty or draining.
  assign s_ready    = !m_valid || m_ready;
  assign accept     = s_valid && s_ready;
  assign frame_done = accept && s_last;
  assign byte_en    = s_last ? s_keep : {KEEP_W{1'b1}};
  assign keep_inc   = s_keep + 1'b1;

  crc_stream_fold #(
    .DATA_WIDTH (DATA_WIDTH),
    .CRC_WIDTH  (CRC_WIDTH),
    .POLY       (POLY),
    .REFIN      (REFIN)
  ) u_fold (
    .lfsr    (lfsr),
    .data    (s_data),
    .byte_en (byte_en),
    .next    (fold_next)
  );

  assign crc_final = (REFOUT ? CRC_WIDTH'(bit_reverse(64'(fold_next), CRC_WIDTH)) : fold_next)
                     ^ XOR_OUT;
  assign frame_ok  = (fold_next == RESIDUE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: frames open on a non-last accept and close on any last accept.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !s_last) state_next = BUSY;
      BUSY:    if (frame_done)        state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Running CRC register; reloads INIT when a frame closes.
  always_ff @(posedge clk) begin
    if (rst)             lfsr <= INIT;
    else if (frame_done) lfsr <= INIT;
    else if (accept)     lfsr <= fold_next;
  end

  // Result slot; a drain and a new result in the same cycle keep m_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_crc   <= '0;
      m_match <= 1'b0;
    end else if (frame_done) begin
      m_valid <= 1'b1;
      m_crc   <= crc_final;
      m_match <= frame_ok;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef CRC_STREAM_STATS_EN
  // Saturating frame and error counters, updated on the edge that raises m_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else if (frame_done) begin
      if (frame_cnt != 32'hFFFF_FFFF)            frame_cnt <= frame_cnt + 32'd1;
      if (!frame_ok && err_cnt != 32'hFFFF_FFFF) err_cnt   <= err_cnt + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

  // Last-beat keep must be a contiguous run starting at byte 0.
  keep_contiguous: assert property (@(posedge clk) disable iff (rst)
    frame_done |-> ((s_keep & keep_inc) == '0));

endmodule

// File: tb/tb_crc_stream.sv
// Self-checking bench for crc_stream: a CRC-16/CCITT-FALSE instance (8-bit beats)
// and a CRC-32 instance (32-bit beats), checked against byte-level reference models.
module tb_crc_stream;

  typedef logic [7:0] bytes_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [7:0]  d16;
  logic        k16, v16, l16, mr16;
  logic        r16, mm16, mv16;
  logic [15:0] crc16;

  logic [31:0] d32;
  logic [3:0]  k32;
  logic        v32, l32, mr32;
  logic        r32, mm32, mv32;
  logic [31:0] crc32;

`ifdef CRC_STREAM_STATS_EN
  logic [31:0] fc16, ec16, fc32, ec32;
`endif
  int exp_fc16 = 0, exp_ec16 = 0, exp_fc32 = 0, exp_ec32 = 0;

  crc_stream dut16 (
    .clk(clk), .rst(rst), .s_data(d16), .s_keep(k16), .s_valid(v16), .s_last(l16),
    .s_ready(r16), .m_crc(crc16), .m_match(mm16), .m_valid(mv16), .m_ready(mr16)
`ifdef CRC_STREAM_STATS_EN
    , .frame_cnt(fc16), .err_cnt(ec16)
`endif
  );

  crc_stream #(
    .DATA_WIDTH(32), .CRC_WIDTH(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
    .XOR_OUT(32'hFFFFFFFF), .REFIN(1'b1), .REFOUT(1'b1), .RESIDUE(32'hC704DD7B)
  ) dut32 (
    .clk(clk), .rst(rst), .s_data(d32), .s_keep(k32), .s_valid(v32), .s_last(l32),
    .s_ready(r32), .m_crc(crc32), .m_match(mm32), .m_valid(mv32), .m_ready(mr32)
`ifdef CRC_STREAM_STATS_EN
    , .frame_cnt(fc32), .err_cnt(ec32)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC-16/CCITT-FALSE, byte-at-a-time: XOR the byte into the top, then 8 divisions.
  function automatic logic [15:0] ref16(input bytes_t q);
    logic [15:0] c = 16'hFFFF;
    foreach (q[i]) begin
      c = c ^ {q[i], 8'h00};
      repeat (8) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // CRC-32 in the reflected domain (LSB-first, reversed polynomial); returns the
  // reflected register, i.e. the bit-reverse of the engine's raw register.
  function automatic logic [31:0] ref32_reg(input bytes_t q);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic beat16(input logic [7:0] data, input logic keep, input logic last);
    int w = 0;
    d16 = data; k16 = keep; l16 = last; v16 = 1'b1;
    while (!r16 && w < 200) begin @(posedge clk); #1; w++; end
    if (w >= 200) chk("s_ready16_timeout", r16, 1);
    @(posedge clk); #1;
    v16 = 1'b0; l16 = 1'b0;
  endtask

  task automatic beat32(input logic [31:0] data, input logic [3:0] keep, input logic last);
    int w = 0;
    d32 = data; k32 = keep; l32 = last; v32 = 1'b1;
    while (!r32 && w < 200) begin @(posedge clk); #1; w++; end
    if (w >= 200) chk("s_ready32_timeout", r32, 1);
    @(posedge clk); #1;
    v32 = 1'b0; l32 = 1'b0;
  endtask

  task automatic check16(input string tag, input bytes_t q);
    logic [15:0] e;
    e = ref16(q);
    chk({tag, "_valid"}, mv16, 1);
    chk({tag, "_crc"}, crc16, e);
    chk({tag, "_match"}, mm16, (e == 16'h0000));
    exp_fc16++;
    if (e != 16'h0000) exp_ec16++;
  endtask

  task automatic send16(input string tag, input bytes_t q);
    if (q.size() == 0) beat16(8'h00, 1'b0, 1'b1);
    else foreach (q[i]) beat16(q[i], 1'b1, (i == q.size() - 1));
    check16(tag, q);
  endtask

  task automatic send32(input string tag, input bytes_t q);
    int nb, beats, idx;
    logic [31:0] data, e;
    logic [3:0]  keep;
    nb = q.size();
    beats = (nb == 0) ? 1 : (nb + 3) / 4;
    for (int b = 0; b < beats; b++) begin
      data = '0; keep = '0;
      for (int j = 0; j < 4; j++) begin
        idx = b * 4 + j;
        if (idx < nb) begin data[8*j +: 8] = q[idx]; keep[j] = 1'b1; end
      end
      beat32(data, keep, (b == beats - 1));
    end
    e = ref32_reg(q);
    chk({tag, "_valid"}, mv32, 1);
    chk({tag, "_crc"}, crc32, e ^ 32'hFFFFFFFF);
    chk({tag, "_match"}, mm32, (e == 32'hDEBB20E3));
    exp_fc32++;
    if (e != 32'hDEBB20E3) exp_ec32++;
  endtask

  function automatic bytes_t rand_bytes(input int n);
    bytes_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(255)));
    return q;
  endfunction

  initial begin
    bytes_t s9, qa, qb, q;
    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    rst = 1'b1;
    d16 = '0; k16 = 1'b0; v16 = 1'b0; l16 = 1'b0; mr16 = 1'b1;
    d32 = '0; k32 = '0;   v32 = 1'b0; l32 = 1'b0; mr32 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst16_valid", mv16, 0);
    chk("rst16_crc", crc16, 0);
    chk("rst16_match", mm16, 0);
    chk("rst16_ready", r16, 1);
    chk("rst32_valid", mv32, 0);
    chk("rst32_crc", crc32, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle16_valid", mv16, 0);

    send16("ccitt_123456789", s9);
    chk("ccitt_known", crc16, 16'h29B1);
    @(posedge clk); #1;
    chk("ccitt_drained", mv16, 0);

    // Reset mid-frame: partial CRC is discarded, no result appears.
    for (int i = 0; i < 4; i++) beat16(s9[i], 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_fc16 = 0; exp_ec16 = 0; exp_fc32 = 0; exp_ec32 = 0;
    for (int i = 0; i < 4; i++) begin
      chk("midrst_no_valid", mv16, 0);
      @(posedge clk); #1;
    end
    send16("ccitt_restart", s9);
    chk("ccitt_restart_known", crc16, 16'h29B1);

    send16("empty16", '{});
    chk("empty16_known", crc16, 16'hFFFF);

    send32("crc32_123456789", s9);
    chk("crc32_known", crc32, 32'hCBF43926);
    chk("crc32_known_match", mm32, 0);

    q = s9;
    q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
    send32("crc32_appended", q);
    chk("crc32_appended_match", mm32, 1);
    q[2] = q[2] ^ 8'h10;
    send32("crc32_corrupt", q);
    chk("crc32_corrupt_match", mm32, 0);

    // Back-to-back with result held: A stays put, B's first beat waits.
    qa = rand_bytes(3);
    qb = rand_bytes(4);
    mr16 = 1'b0;
    send16("hold_a", qa);
    d16 = qb[0]; k16 = 1'b1; l16 = 1'b0; v16 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold_ready", r16, 0);
      chk("hold_valid", mv16, 1);
      chk("hold_crc", crc16, ref16(qa));
    end
    mr16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0;
    chk("release_drain", mv16, 0);
    for (int i = 1; i < qb.size(); i++) beat16(qb[i], 1'b1, (i == qb.size() - 1));
    check16("hold_b", qb);

    // Random frames, both engines, continuous drain.
    for (int f = 0; f < 15; f++) begin
      send16($sformatf("rnd16_%0d", f), rand_bytes($urandom_range(1, 10)));
      send32($sformatf("rnd32_%0d", f), rand_bytes($urandom_range(0, 13)));
    end
    // Random frames with a valid appended CRC must hit the residue.
    for (int f = 0; f < 5; f++) begin
      logic [31:0] c;
      q = rand_bytes($urandom_range(1, 11));
      c = ref32_reg(q) ^ 32'hFFFFFFFF;
      for (int j = 0; j < 4; j++) q.push_back(c[8*j +: 8]);
      send32($sformatf("rnd32_resid_%0d", f), q);
      chk("rnd32_resid_match", mm32, 1);
    end

`ifdef CRC_STREAM_STATS_EN
    chk("stats16_frames", fc16, exp_fc16);
    chk("stats16_errs", ec16, exp_ec16);
    chk("stats32_frames", fc32, exp_fc32);
    chk("stats32_errs", ec32, exp_ec32);
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
